// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants and state type for the seven-segment scan controller.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam logic [7:0] SEG_ZERO = 8'hC0;
    localparam logic [7:0] SEG_ONE  = 8'hF9;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    typedef enum logic [1:0] {
        GAP   = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake between the ALU result register and the scan controller.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic                  load_valid;
    logic                  load_ready;
    logic [NUM_DIGITS-1:0] load_data;

    modport master (output load_valid, output load_data, input  load_ready);
    modport slave  (input  load_valid, input  load_data, output load_ready);

endinterface

// File: rtl/seven_seg_scan_ctrl_seg_bit_decode.sv
// Maps one binary digit to its segment pattern; show_i=0 forces the bus dark.
module seg_bit_decode
    import seven_seg_pkg::*;
(
    input  logic       bit_i,
    input  logic       show_i,
    output logic [7:0] seg_o
);

    assign seg_o = !show_i ? SEG_OFF : (bit_i ? SEG_ONE : SEG_ZERO);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of a binary value onto a common-anode display bank,
// with frame-aligned value commits. Optional macro: LEADING_ZERO_BLANK_EN.
//
// state | meaning
// GAP   | all anodes off for GAP_CYCLES between digit slots
// SCAN  | digit idx lit for REFRESH_DIV cycles
// BLANK | display forced dark, loads commit immediately
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_seg_scan_ctrl_if.slave  load_if,
    input  logic                  blank_i,
    output logic [7:0]            seg_out_o,
    output logic [NUM_DIGITS-1:0] digit_en_n_o,
    output logic                  frame_done_o
);

    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PMAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int PW   = $clog2(PMAX);

    scan_state_t           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0] pdata_q, pdata_d;
    logic                  pend_q, pend_d;
    logic                  ready_q, ready_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] den_q, den_d;
    logic                  fdone_q;

    logic xfer, slot_end, last_digit, boundary, show_d;

    assign xfer       = load_if.load_valid && ready_q;
    assign slot_end   = (presc_q == PW'(REFRESH_DIV - 1));
    assign last_digit = (idx_q == IW'(NUM_DIGITS - 1));
    assign boundary   = !blank_i && (state_q == SCAN) && slot_end && last_digit;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q + PW'(1);
        case (state_q)
            GAP: begin
                if (presc_q == PW'(GAP_CYCLES - 1)) begin
                    state_d = SCAN;
                    presc_d = '0;
                end
            end
            SCAN: begin
                if (slot_end) begin
                    state_d = GAP;
                    presc_d = '0;
                    idx_d   = last_digit ? '0 : idx_q + IW'(1);
                end
            end
            BLANK: begin
                state_d = GAP;
                presc_d = '0;
                idx_d   = '0;
            end
            default: begin
                state_d = GAP;
                presc_d = '0;
                idx_d   = '0;
            end
        endcase
        if (blank_i) begin
            state_d = BLANK;
            presc_d = '0;
            idx_d   = '0;
        end
    end

    // Loads landing on a frame boundary or while blanked bypass the pending slot.
    always_comb begin
        disp_d  = disp_q;
        pdata_d = pdata_q;
        pend_d  = pend_q;
        ready_d = ready_q;
        if (boundary || (state_q == BLANK)) begin
            if (xfer) begin
                disp_d = load_if.load_data;
            end else if (pend_q) begin
                disp_d = pdata_q;
            end
            pend_d  = 1'b0;
            ready_d = 1'b1;
        end else if (xfer) begin
            pdata_d = load_if.load_data;
            pend_d  = 1'b1;
            ready_d = 1'b0;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign show_d = (idx_d == '0) || ((disp_d >> idx_d) != '0);
`else
    assign show_d = 1'b1;
`endif

    // Outputs are decoded from next-state values so they can be registered.
    seg_bit_decode u_decode (
        .bit_i  (disp_d[idx_d]),
        .show_i ((state_d == SCAN) && show_d),
        .seg_o  (seg_d)
    );

    always_comb begin
        den_d = '1;
        if (state_d == SCAN) begin
            den_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GAP;
            idx_q   <= '0;
            presc_q <= '0;
            disp_q  <= '0;
            pdata_q <= '0;
            pend_q  <= 1'b0;
            ready_q <= 1'b1;
            seg_q   <= SEG_OFF;
            den_q   <= '1;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            disp_q  <= disp_d;
            pdata_q <= pdata_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            seg_q   <= seg_d;
            den_q   <= den_d;
            fdone_q <= boundary;
        end
    end

    assign load_if.load_ready = ready_q;
    assign seg_out_o          = seg_q;
    assign digit_en_n_o       = den_q;
    assign frame_done_o       = fdone_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position model compared every cycle,
// plus directed literal checks. Honours LEADING_ZERO_BLANK_EN when defined.
module tb_seven_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int G     = 1;
    localparam int P     = G + R;
    localparam int FRAME = P * N;

`ifdef LEADING_ZERO_BLANK_EN
    localparam int LZB = 1;
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam int LZB = 0;
    localparam logic [7:0] LZ = 8'hC0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         blank = 1'b0;
    logic [7:0]   seg;
    logic [N-1:0] den;
    logic         fd;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) lif ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .GAP_CYCLES  (G)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_if      (lif),
        .blank_i      (blank),
        .seg_out_o    (seg),
        .digit_en_n_o (den),
        .frame_done_o (fd)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: position within a FRAME-cycle frame; t%P < G is the dark gap.
    int m_t = 0, m_inblank = 0, m_disp = 0, m_pdata = 0, m_pend = 0, m_ready = 1, m_fd = 0;
    int bnd, xf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_inblank = 0; m_disp = 0; m_pdata = 0;
            m_pend = 0; m_ready = 1; m_fd = 0;
        end else begin
            bnd = (m_inblank == 0 && blank == 1'b0 && m_t == FRAME - 1) ? 1 : 0;
            xf  = (lif.load_valid == 1'b1 && m_ready == 1) ? 1 : 0;
            if (bnd == 1 || m_inblank == 1) begin
                if (xf == 1) m_disp = 32'(lif.load_data);
                else if (m_pend == 1) m_disp = m_pdata;
                m_pend = 0; m_ready = 1;
            end else if (xf == 1) begin
                m_pdata = 32'(lif.load_data); m_pend = 1; m_ready = 0;
            end
            m_fd = bnd;
            if (blank) begin
                m_inblank = 1; m_t = 0;
            end else if (m_inblank == 1) begin
                m_inblank = 0; m_t = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
        end
    end

    int e_seg, e_den, slot;
    always @(negedge clk) begin
        if (m_inblank == 1 || (m_t % P) < G) begin
            e_seg = 'hFF;
            e_den = (1 << N) - 1;
        end else begin
            slot  = m_t / P;
            e_den = ~(1 << slot) & ((1 << N) - 1);
            e_seg = (((m_disp >> slot) & 1) == 1) ? 'hF9 : 'hC0;
            if (LZB == 1 && slot > 0 && (m_disp >> slot) == 0) e_seg = 'hFF;
        end
        chk("cyc_seg_out", 32'(seg), 32'(e_seg));
        chk("cyc_digit_en_n", 32'(den), 32'(e_den));
        chk("cyc_load_ready", 32'(lif.load_ready), 32'(m_ready));
        chk("cyc_frame_done", 32'(fd), 32'(m_fd));
        chk("cyc_one_anode", 32'($countones(~den) <= 1), 32'd1);
    end

    task automatic wait_lit(input int d, input logic [7:0] exp, input string name);
        logic [N-1:0] m;
        int n = 0;
        m = N'(~(32'd1 << d));
        while (den !== m && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk({name, "_timeout"}, 32'(den), 32'(m));
        else chk(name, 32'(seg), 32'(exp));
    endtask

    task automatic wait_fd(input string name);
        int n = 0;
        while (fd !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk({name, "_timeout"}, 32'(fd), 32'd1);
    endtask

    task automatic offer(input logic [N-1:0] d);
        lif.load_valid = 1'b1;
        lif.load_data  = d;
        @(negedge clk);
        lif.load_valid = 1'b0;
        lif.load_data  = N'($urandom);
    endtask

    int t0;

    initial begin
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_den", 32'(den), 32'hF);
        chk("rst_ready", 32'(lif.load_ready), 32'd1);
        chk("rst_fd", 32'(fd), 32'd0);
        rst_n = 1'b1;

        // 0101: alternating digits, 20-cycle frames
        offer(4'b0101);
        wait_fd("t1_fd0");
        t0 = cyc;
        wait_lit(0, 8'hF9, "t1_d0");
        wait_lit(1, 8'hC0, "t1_d1");
        wait_lit(2, 8'hF9, "t1_d2");
        wait_lit(3, LZ, "t1_d3");
        wait_fd("t1_fd1");
        chk("t1_frame_period", 32'(cyc - t0), 32'd20);

        // second offer held off until the boundary commits 1111
        wait_lit(1, 8'hC0, "t2_old_d1");
        offer(4'b1111);
        lif.load_valid = 1'b1;
        lif.load_data  = 4'b0000;
        @(negedge clk);
        chk("t2_held_off", 32'(lif.load_ready), 32'd0);
        wait_lit(3, LZ, "t2_old_d3");
        wait_fd("t2_fd");
        @(negedge clk);
        lif.load_valid = 1'b0;
        wait_lit(0, 8'hF9, "t2_new_d0");
        wait_lit(3, 8'hF9, "t2_new_d3");
        chk("t2_second_pending", 32'(lif.load_ready), 32'd0);
        wait_fd("t2_fd2");
        wait_lit(0, 8'hC0, "t2_zero_d0");

        // transfer on the boundary cycle bypasses straight to the display
        wait_lit(3, LZ, "t3_zero_d3");
        repeat (3) @(negedge clk);
        lif.load_valid = 1'b1;
        lif.load_data  = 4'b0011;
        @(negedge clk);
        lif.load_valid = 1'b0;
        chk("t3_boundary_fd", 32'(fd), 32'd1);
        chk("t3_ready_kept", 32'(lif.load_ready), 32'd1);
        wait_lit(0, 8'hF9, "t3_d0");
        chk("t3_ready_still", 32'(lif.load_ready), 32'd1);
        wait_lit(1, 8'hF9, "t3_d1");
        wait_lit(2, LZ, "t3_d2");
        wait_lit(3, LZ, "t3_d3");

        // blank during digit2, load commits at once
        wait_lit(2, LZ, "t4_pre_d2");
        blank = 1'b1;
        @(negedge clk);
        chk("t4_dark_seg", 32'(seg), 32'hFF);
        chk("t4_dark_den", 32'(den), 32'hF);
        offer(4'b1000);
        chk("t4_ready_blank", 32'(lif.load_ready), 32'd1);
        repeat (2) @(negedge clk);
        blank = 1'b0;
        @(negedge clk);
        chk("t4_gap_den", 32'(den), 32'hF);
        wait_lit(0, 8'hC0, "t4_d0");
        wait_lit(1, 8'hC0, "t4_d1");
        wait_lit(2, 8'hC0, "t4_d2");
        wait_lit(3, 8'hF9, "t4_d3");

        // reset mid-scan discards the pending value
        wait_lit(1, 8'hC0, "t5_pre_d1");
        offer(4'b0110);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_seg", 32'(seg), 32'hFF);
        chk("t5_rst_den", 32'(den), 32'hF);
        chk("t5_rst_ready", 32'(lif.load_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_lit(1, LZ, "t5_d1_after_rst");
        wait_fd("t5_fd");
        wait_lit(1, LZ, "t5_pending_lost");

`ifdef LEADING_ZERO_BLANK_EN
        offer(4'b0010);
        wait_fd("t6_fd0");
        wait_lit(0, 8'hC0, "t6_d0");
        wait_lit(1, 8'hF9, "t6_d1");
        wait_lit(2, 8'hFF, "t6_d2");
        wait_lit(3, 8'hFF, "t6_d3");
        offer(4'b0000);
        wait_fd("t6_fd1");
        wait_lit(0, 8'hC0, "t6_zero_d0");
        wait_lit(1, 8'hFF, "t6_zero_d1");
        wait_lit(2, 8'hFF, "t6_zero_d2");
        wait_lit(3, 8'hFF, "t6_zero_d3");
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
